wb_sram_dual_port_arbiter: RTL and testbench



---
 rtl/wb_sram_arb_pkg.sv | 23 ++
 rtl/generic_sram_line_en_if.sv | 22 ++
 rtl/wb_if.sv | 27 ++
 rtl/wb_rr_arbiter2.sv | 40 ++++
 rtl/wb_sram_dual_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_sram_dual_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/wb_sram_arb_pkg.sv
// Shared types and constants for the dual-port Wishbone SRAM arbiter.
// FSM states, port id and word-offset helper.
package wb_sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  typedef logic port_t;

  localparam int unsigned BURST_W = 4;
  localparam int unsigned LAT_W   = 2;

  function automatic int unsigned word_off(
    input int unsigned dw
  );
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/generic_sram_line_en_if.sv
// Generic line-enable SRAM port.
// The client drives address and enables; the macro returns read_data.
interface generic_sram_line_en_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) ();
  logic [AW-1:0] addr;
  logic          read_en;
  logic          write_en;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;

  modport sram_client (
    output addr, read_en, write_en, write_data,
    input  read_data
  );

  modport sram (
    input  addr, read_en, write_en, write_data,
    output read_data
  );
endinterface

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle.
// Slave modport for the arbiter, master modport for initiators.
interface wb_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) ();
  logic          CYC;
  logic          STB;
  logic          WE;
  logic [AW-1:0] ADR;
  logic [DW-1:0] DAT_W;
  logic [DW-1:0] DAT_R;
  logic [DW/8-1:0] SEL;
  logic          ACK;
  logic          ERR;
  logic          TGD_R;

  modport slave (
    input  CYC, STB, WE, ADR, DAT_W, SEL,
    output ACK, ERR, DAT_R, TGD_R
  );

  modport master (
    output CYC, STB, WE, ADR, DAT_W, SEL,
    input  ACK, ERR, DAT_R, TGD_R
  );
endinterface

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin grant with a bounded bus lock.
// i_lock marks the slot after a completed transaction.
module wb_rr_arbiter2
  import wb_sram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic [1:0]         i_req,
  input  logic               i_lock,
  input  port_t              i_last_grant,
  input  port_t              i_owner,
  input  logic [BURST_W-1:0] i_burst_cnt,
  output logic               o_grant,
  output port_t              o_owner,
  output logic               o_fresh
);

  localparam logic [BURST_W-1:0] BURST_MAX =
    BURST_W'(MAX_BURST);

  port_t w_last;
  logic  w_keep;

  // i_burst_cnt already includes the transaction just finished
  always_comb begin
    w_last  = i_lock ? i_owner : i_last_grant;
    w_keep  = i_lock && i_req[i_owner] &&
              (!i_req[~i_owner] ||
               (i_burst_cnt < BURST_MAX));
    o_grant = |i_req;
    o_owner = i_owner;
    o_fresh = 1'b0;
    if (!w_keep) begin
      o_fresh = 1'b1;
      if (&i_req) o_owner = ~w_last;
      else        o_owner = i_req[1];
    end
  end

endmodule

// File: rtl/wb_sram_dual_port_arbiter.sv
// Two Wishbone slave ports sharing one line-enable SRAM.
// Round-robin with bounded burst lock; 1-cycle write, N-cycle read.
module wb_sram_dual_port_arbiter
  import wb_sram_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned MAX_BURST     = 4
) (
  input  logic clk,
  input  logic rstn,
  wb_if.slave  wb_s0,
  wb_if.slave  wb_s1,
  generic_sram_line_en_if.sram_client sram_m
);

  localparam int unsigned OFF = word_off(DATA_WIDTH);
  localparam int unsigned SAW = ADDRESS_WIDTH - OFF;
  localparam logic [LAT_W-1:0] LAT_LAST =
    LAT_W'(READ_LATENCY - 1);
  localparam logic [BURST_W-1:0] BURST_MAX =
    BURST_W'(MAX_BURST);

  state_t             r_state, w_state_n;
  port_t              r_owner, w_owner_n;
  port_t              r_last, w_last_n;
  logic [BURST_W-1:0] r_burst, w_burst_n;
  logic [LAT_W-1:0]   r_lat, w_lat_n;

  logic [1:0]          w_req;
  logic                w_lock;
  logic [BURST_W-1:0]  w_cnt_inc;
  logic                w_gnt;
  port_t               w_gnt_owner;
  logic                w_fresh;
  logic                w_we_new;
  logic [SAW-1:0]      w_adr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic                w_ack;
  logic                w_rd_ack;
  logic                w_unused;

  assign w_req = {wb_s1.CYC & wb_s1.STB,
                  wb_s0.CYC & wb_s0.STB};
  assign w_lock = (r_state == DONE);
  assign w_cnt_inc = (r_burst >= BURST_MAX) ?
                     BURST_MAX : r_burst + 4'd1;

  assign w_we_new = w_gnt_owner ? wb_s1.WE : wb_s0.WE;
  assign w_adr = r_owner ?
    wb_s1.ADR[ADDRESS_WIDTH-1:OFF] :
    wb_s0.ADR[ADDRESS_WIDTH-1:OFF];
  assign w_dat = r_owner ? wb_s1.DAT_W : wb_s0.DAT_W;

  assign w_unused = ^{wb_s0.SEL, wb_s1.SEL,
                      wb_s0.ADR[OFF-1:0],
                      wb_s1.ADR[OFF-1:0]};

  wb_rr_arbiter2 #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .i_req       (w_req),
    .i_lock      (w_lock),
    .i_last_grant(r_last),
    .i_owner     (r_owner),
    .i_burst_cnt (w_cnt_inc),
    .o_grant     (w_gnt),
    .o_owner     (w_gnt_owner),
    .o_fresh     (w_fresh)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_burst <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_last  <= w_last_n;
      r_burst <= w_burst_n;
      r_lat   <= w_lat_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_last_n  = r_last;
    w_burst_n = r_burst;
    w_lat_n   = r_lat;
    unique case (r_state)
      IDLE: begin
        if (w_gnt) begin
          w_owner_n = w_gnt_owner;
          w_burst_n = '0;
          w_lat_n   = '0;
          w_state_n = w_we_new ? WR : RD;
        end
      end
      WR: w_state_n = DONE;
      RD: begin
        if (r_lat == LAT_LAST) w_state_n = DONE;
        else w_lat_n = r_lat + 2'd1;
      end
      DONE: begin
        w_last_n  = r_owner;
        w_lat_n   = '0;
        w_burst_n = w_cnt_inc;
        w_state_n = IDLE;
        if (w_gnt) begin
          w_owner_n = w_gnt_owner;
          if (w_fresh) w_burst_n = '0;
          w_state_n = w_we_new ? WR : RD;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign w_rd_ack = (r_state == RD) && (r_lat == LAT_LAST);
  assign w_ack = (r_state == WR) || w_rd_ack;

  always_comb begin
    sram_m.addr       = '0;
    sram_m.read_en    = 1'b0;
    sram_m.write_en   = 1'b0;
    sram_m.write_data = '0;
    if (r_state == WR) begin
      sram_m.addr       = w_adr;
      sram_m.write_en   = 1'b1;
      sram_m.write_data = w_dat;
    end else if (r_state == RD) begin
      sram_m.addr    = w_adr;
      sram_m.read_en = 1'b1;
    end
  end

  assign wb_s0.ACK = w_ack & ~r_owner;
  assign wb_s1.ACK = w_ack & r_owner;
  assign wb_s0.DAT_R = (w_rd_ack && !r_owner) ?
                       sram_m.read_data : '0;
  assign wb_s1.DAT_R = (w_rd_ack && r_owner) ?
                       sram_m.read_data : '0;
  assign wb_s0.ERR   = 1'b0;
  assign wb_s1.ERR   = 1'b0;
  assign wb_s0.TGD_R = 1'b0;
  assign wb_s1.TGD_R = 1'b0;

endmodule

// File: tb/tb_wb_sram_dual_port_arbiter.sv
// Bench for the dual-port SRAM arbiter: directed timing cases plus
// random two-master traffic scored against a word-array memory model.
module tb_wb_sram_dual_port_arbiter;

  localparam int RL  = 2;
  localparam int RLB = 3;
  localparam int MB  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic do_init = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   nack0 = 0;
  int   nack1 = 0;
  int   nren = 0;
  int   nwen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_if #(.AW(10), .DW(32)) wb0 ();
  wb_if #(.AW(10), .DW(32)) wb1 ();
  wb_if #(.AW(10), .DW(32)) wbb0 ();
  wb_if #(.AW(10), .DW(32)) wbb1 ();
  generic_sram_line_en_if #(.AW(8), .DW(32)) sa ();
  generic_sram_line_en_if #(.AW(8), .DW(32)) sb ();

  wb_sram_dual_port_arbiter #(
    .ADDRESS_WIDTH(10), .DATA_WIDTH(32),
    .READ_LATENCY(RL), .MAX_BURST(MB)
  ) dut_a (
    .clk(clk), .rstn(rstn),
    .wb_s0(wb0), .wb_s1(wb1), .sram_m(sa)
  );

  wb_sram_dual_port_arbiter #(
    .ADDRESS_WIDTH(10), .DATA_WIDTH(32),
    .READ_LATENCY(RLB), .MAX_BURST(MB)
  ) dut_b (
    .clk(clk), .rstn(rstn),
    .wb_s0(wbb0), .wb_s1(wbb1), .sram_m(sb)
  );

  function automatic logic [31:0] seed(input logic [7:0] a);
    return {8'h5A, a, ~a, a ^ 8'hC3};
  endfunction

  function automatic logic [31:0] fnb(input logic [7:0] a);
    return {a, ~a, a ^ 8'h3C, 8'hA5};
  endfunction

  // SRAM macro models: A has READ_LATENCY 2, B has 3
  logic [31:0] mem_a [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pa, pb1, pb2;

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= seed(8'(i));
    end else if (sa.write_en) begin
      mem_a[sa.addr] <= sa.write_data;
    end
    pa  <= mem_a[sa.addr];
    pb1 <= fnb(sb.addr);
    pb2 <= pb1;
  end

  assign sa.read_data = pa;
  assign sb.read_data = pb2;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wb0.ACK) nack0 <= nack0 + 1;
    if (wb1.ACK) nack1 <= nack1 + 1;
    if (sa.read_en) nren <= nren + 1;
    if (sa.write_en) nwen <= nwen + 1;
    if (rstn) begin
      chk("one_ack", {63'd0, wb0.ACK & wb1.ACK}, 0);
      chk("en_excl", {63'd0, sa.read_en & sa.write_en}, 0);
      if (!sa.read_en && !sa.write_en)
        chk("idle_bus", {24'd0, sa.addr, sa.write_data}, 0);
      chk("err_tgd", {60'd0, wb0.ERR, wb1.ERR,
                      wb0.TGD_R, wb1.TGD_R}, 0);
    end
  end

  task automatic drive(input int p, input bit c, input bit we,
                       input logic [9:0] adr,
                       input logic [31:0] dat);
    if (p == 0) begin
      wb0.CYC = c; wb0.STB = c; wb0.WE = we;
      wb0.ADR = adr; wb0.DAT_W = dat;
    end else begin
      wb1.CYC = c; wb1.STB = c; wb1.WE = we;
      wb1.ADR = adr; wb1.DAT_W = dat;
    end
  endtask

  task automatic idle(input int p);
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  // One Wishbone cycle on dut_a; returns at posedge+1 after the ACK
  task automatic xfer(input int p, input bit we,
                      input logic [9:0] adr,
                      input logic [31:0] dat,
                      output int t0, output int ta,
                      output logic [31:0] rd);
    int oth0;
    int w;
    drive(p, 1'b1, we, adr, dat);
    t0 = cyc;
    ta = -1;
    rd = '0;
    oth0 = (p != 0) ? nack0 : nack1;
    for (int i = 0; i < 80 && ta < 0; i++) begin
      @(negedge clk);
      if ((p != 0) ? wb1.ACK : wb0.ACK) begin
        ta = cyc;
        rd = (p != 0) ? wb1.DAT_R : wb0.DAT_R;
        w = ((p != 0) ? nack0 : nack1) - oth0;
        chk("fair_wait", 64'(w), (w > MB) ? 64'(MB) : 64'(w));
        if (we) begin
          chk("wr_en", {63'd0, sa.write_en}, 1);
          chk("wr_addr", {56'd0, sa.addr}, {56'd0, adr[9:2]});
          chk("wr_data", {32'd0, sa.write_data}, {32'd0, dat});
          ref_mem[adr[9:2]] = dat;
        end else begin
          chk("rd_data", {32'd0, rd},
              {32'd0, ref_mem[adr[9:2]]});
        end
      end
    end
    if (ta < 0) chk("ack_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(0);
    idle(1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_ack0", {63'd0, wb0.ACK}, 0);
    chk("rst_ack1", {63'd0, wb1.ACK}, 0);
    chk("rst_en", {62'd0, sa.read_en, sa.write_en}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int s0, a0, s1, a1, sb0, b0, sb1, b1, n, t, r_n0;
  logic [31:0] r0, r1, rb0, rb1;
  logic [9:0] badr;
  int p0_acks [8];
  bit p1_first;
  int nacks, last, renb, ren0, wen0;
  bit seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(8'(i));
    idle(0);
    idle(1);
    wb0.SEL = 4'hF; wb1.SEL = 4'hF;
    wbb0.CYC = 0; wbb0.STB = 0; wbb0.WE = 0;
    wbb0.ADR = '0; wbb0.DAT_W = '0; wbb0.SEL = 4'hF;
    wbb1.CYC = 0; wbb1.STB = 0; wbb1.WE = 0;
    wbb1.ADR = '0; wbb1.DAT_W = '0; wbb1.SEL = 4'hF;
    repeat (2) @(posedge clk);
    #1 do_init = 1'b0;
    @(negedge clk);
    chk("reset_ack", {62'd0, wb0.ACK, wb1.ACK}, 0);
    chk("reset_en", {62'd0, sa.read_en, sa.write_en}, 0);
    chk("reset_b_en", {63'd0, sb.read_en}, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // single write then read on port 0
    wen0 = nwen;
    xfer(0, 1'b1, 10'h10, 32'hDEADBEEF, s0, a0, r0);
    chk("t1_wr_lat", 64'(a0 - s0), 1);
    chk("t1_wen_cycles", 64'(nwen - wen0), 1);
    ren0 = nren;
    xfer(0, 1'b0, 10'h10, '0, s0, a0, r0);
    idle(0);
    chk("t1_rd_data", {32'd0, r0}, 64'hDEADBEEF);
    chk("t1_rd_lat", 64'(a0 - s0), RL);
    chk("t1_ren_cycles", 64'(nren - ren0), RL);

    // simultaneous reads from reset, then a back-to-back repeat
    do_reset();
    p1_first = 1'b0;
    fork
      begin
        xfer(0, 1'b0, 10'h000, '0, s0, a0, r0);
        idle(0);
        wait (p1_first);
        xfer(0, 1'b0, 10'h000, '0, sb0, b0, rb0);
        idle(0);
      end
      begin
        xfer(1, 1'b0, 10'h004, '0, s1, a1, r1);
        p1_first = 1'b1;
        xfer(1, 1'b0, 10'h004, '0, sb1, b1, rb1);
        idle(1);
      end
    join
    chk("t2_p0_first", 64'(a1 - a0), RL + 1);
    chk("t2_p1_kept", 64'(b1 - a1), RL + 1);
    chk("t2_p1_first", 64'(b0 - b1), RL + 1);
    @(posedge clk);
    #1;

    // port 0 streams reads while port 1 asks once
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          xfer(0, 1'b0, 10'($urandom_range(0, 255) * 4), '0,
               s0, t, r0);
          p0_acks[i] = t;
        end
        idle(0);
      end
      begin
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 10'h0C8, '0, s1, a1, r1);
        idle(1);
      end
    join
    n = 0;
    for (int i = 0; i < 8; i++) if (p0_acks[i] < a1) n++;
    chk("t3_burst_len", 64'(n), MB);
    chk("t3_p1_wait_ok",
        {63'd0, (a1 - s1) <= MB * (RL + 1) + RL}, 1);
    chk("t3_p0_resume", 64'(p0_acks[MB] - a1), RL + 1);
    @(posedge clk);
    #1;

    // READ_LATENCY 3 instance, port 1 only
    nacks = 0; last = 0; renb = 0;
    badr = 10'($urandom_range(0, 255) * 4);
    wbb1.ADR = badr; wbb1.WE = 1'b0;
    wbb1.CYC = 1'b1; wbb1.STB = 1'b1;
    for (int i = 0; i < 60 && nacks < 3; i++) begin
      @(negedge clk);
      if (sb.read_en) renb++;
      chk("t4_p0_quiet", {63'd0, wbb0.ACK}, 0);
      if (wbb1.ACK) begin
        chk("t4_data", {32'd0, wbb1.DAT_R},
            {32'd0, fnb(badr[9:2])});
        if (nacks == 0) chk("t4_first_ack", 64'(renb), RLB);
        else chk("t4_period", 64'(cyc - last), RLB + 1);
        last = cyc;
        nacks++;
        @(posedge clk);
        #1;
        badr = 10'($urandom_range(0, 255) * 4);
        wbb1.ADR = badr;
      end
    end
    if (nacks < 3) chk("t4_timeout", 64'(nacks), 3);
    wbb1.CYC = 1'b0; wbb1.STB = 1'b0;
    @(posedge clk);
    #1;

    // asynchronous reset during the first read cycle
    r_n0 = nack0;
    drive(0, 1'b1, 1'b0, 10'h040, '0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = sa.read_en;
    end
    chk("t5_rd_started", {63'd0, seen}, 1);
    rstn = 1'b0;
    #1;
    chk("t5_ren_async", {63'd0, sa.read_en}, 0);
    chk("t5_ack_async", {63'd0, wb0.ACK}, 0);
    idle(0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_ack", 64'(nack0 - r_n0), 0);
    fork
      xfer(0, 1'b0, 10'h040, '0, s0, a0, r0);
      xfer(1, 1'b0, 10'h044, '0, s1, a1, r1);
    join
    idle(0);
    idle(1);
    chk("t5_p0_first", {63'd0, a0 < a1}, 1);

    // write and read of the same word requested together
    @(posedge clk);
    #1;
    fork
      xfer(0, 1'b1, 10'h020, 32'h1111_2222, s0, a0, r0);
      xfer(1, 1'b0, 10'h020, '0, s1, a1, r1);
    join
    idle(0);
    idle(1);
    chk("t6_order", {63'd0, a0 < a1}, 1);
    chk("t6_rd", {32'd0, r1}, 64'h1111_2222);

    // aborted read must still complete and return to idle
    @(posedge clk);
    #1;
    r_n0 = nack0;
    drive(0, 1'b1, 1'b0, 10'h084, '0);
    @(posedge clk);
    #1 idle(0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_ack", 64'(nack0 - r_n0), 1);
    xfer(0, 1'b0, 10'h084, '0, s0, a0, r0);
    idle(0);
    chk("abort_idle", 64'(a0 - s0), RL);

    // random two-master traffic on a small shared window
    fork
      for (int k = 0; k < 40; k++) begin
        int g;
        int x0, x1;
        logic [31:0] xr;
        xfer(0, 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 31)), $urandom, x0, x1, xr);
        g = $urandom_range(0, 2);
        if (g != 0) begin
          idle(0);
          repeat (g) @(posedge clk);
          #1;
        end
      end
      for (int k = 0; k < 40; k++) begin
        int g;
        int x0, x1;
        logic [31:0] xr;
        xfer(1, 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 31)), $urandom, x0, x1, xr);
        g = $urandom_range(0, 2);
        if (g != 0) begin
          idle(1);
          repeat (g) @(posedge clk);
          #1;
        end
      end
    join
    idle(0);
    idle(1);
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
